// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared command codes, H-bridge direction encodings and the
//               per-wheel reversal state machine type for the motor driver.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    // Commands issued by the line-tracker stage
    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_FWD   = 2'b11;

    // H-bridge input pair {INa, INb}; 2'b11 (brake) is never driven
    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_COAST = 2'b00;

    // Per-wheel reversal sequencing
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        DEAD  = 2'b10
    } wheel_state_e;

endpackage
`default_nettype wire

// File: rtl/motor_driver_wheel_channel.sv
`default_nettype none
// ============================================================================
// Module      : wheel_channel
// Description : One wheel of the motor driver. Ramps the duty toward its
//               target, sequences direction reversals through a drain to
//               zero duty and a fixed coast interval, and produces the
//               registered PWM enable and bridge direction pair.
// Revision    : 1.0 - initial release
// ============================================================================
module wheel_channel
    import motor_pkg::*;
#(
    parameter int CNT_W       = 10,
    parameter int RAMP_STEP   = 50,
    parameter int DEAD_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       dir_tgt,
    input  logic             dir_keep,
    input  logic [CNT_W-1:0] duty_tgt,
    input  logic             ramp_tick,
    input  logic [CNT_W-1:0] pwm_cnt,
    output logic             pwm,
    output logic [1:0]       dir
);

    localparam int              DEAD_W    = $clog2(DEAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] STEP     = CNT_W'(RAMP_STEP);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    wheel_state_e      state_q, state_d;
    logic [CNT_W-1:0]  duty_q, duty_d;
    logic [1:0]        dir_cur_q, dir_cur_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [1:0]        dir_o_q, dir_o_d;
    logic              pwm_q, pwm_d;

    logic [1:0]        dir_eff;
    logic              dir_match;
    logic [CNT_W-1:0]  duty_eff;
    logic [CNT_W-1:0]  gap;
    logic [CNT_W-1:0]  step_amt;
    logic              coast;

    // Resolve the requested direction; a stop command keeps the current one
    always_comb begin
        dir_eff   = dir_keep ? dir_cur_q : dir_tgt;
        dir_match = (dir_eff == dir_cur_q);
    end

    // Ramp duty toward the effective target, clamped so it never overshoots
    always_comb begin
        duty_eff = (dir_match && (state_q != DEAD)) ? duty_tgt : '0;
        if (duty_q < duty_eff) begin
            gap = duty_eff - duty_q;
        end else begin
            gap = duty_q - duty_eff;
        end
        step_amt = (gap > STEP) ? STEP : gap;
        duty_d   = duty_q;
        if (ramp_tick) begin
            if (duty_q < duty_eff) begin
                duty_d = duty_q + step_amt;
            end else begin
                duty_d = duty_q - step_amt;
            end
        end
    end

    // Reversal sequencing: drain to zero, coast for the dead interval, flip
    always_comb begin
        state_d    = state_q;
        dir_cur_d  = dir_cur_q;
        dead_cnt_d = dead_cnt_q;
        unique case (state_q)
            RUN: begin
                if (!dir_match) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dir_match) begin
                    // Request withdrawn before reaching zero: no coast owed
                    state_d = RUN;
                end else if (duty_q == '0) begin
                    state_d    = DEAD;
                    dead_cnt_d = '0;
                end
            end
            DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    // Latest request wins even if it changed while coasting
                    dir_cur_d  = dir_eff;
                    dead_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output decode from next-state values so outputs track the state flops
    always_comb begin
        coast   = (state_d == DEAD) || ((duty_d == '0) && (duty_tgt == '0));
        dir_o_d = coast ? DIR_COAST : dir_cur_d;
        pwm_d   = (state_d != DEAD) && (pwm_cnt < duty_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            duty_q     <= '0;
            dir_cur_q  <= DIR_FWD;
            dead_cnt_q <= '0;
            dir_o_q    <= DIR_COAST;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_cur_q  <= dir_cur_d;
            dead_cnt_q <= dead_cnt_d;
            dir_o_q    <= dir_o_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm = pwm_q;
    assign dir = dir_o_q;

endmodule
`default_nettype wire

// File: rtl/motor_driver.sv
`default_nettype none
// ============================================================================
// Module      : motor_driver
// Description : Converts the tracker's 2-bit steering command into per-wheel
//               PWM enables and L298N-style direction pairs. Holds the input
//               debounce filter, pivot escalation timer, ramp divider, shared
//               PWM counter and command-to-wheel target mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_driver
    import motor_pkg::*;
#(
    parameter int CNT_W         = 10,
    parameter int PWM_PERIOD    = 1000,
    parameter int DUTY_FULL     = 800,
    parameter int DUTY_TURN     = 400,
    parameter int RAMP_DIV      = 1000,
    parameter int RAMP_STEP     = 50,
    parameter int FILTER_CYCLES = 4,
    parameter int PIVOT_CYCLES  = 50000,
    parameter int DEAD_CYCLES   = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic [1:0] cmd_active,
    output logic       pivot
);

    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);
    localparam int PIV_W  = $clog2(PIVOT_CYCLES + 1);
    localparam int DIV_W  = $clog2(RAMP_DIV + 1);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DUTY_FULL);
    localparam logic [CNT_W-1:0] TURN = CNT_W'(DUTY_TURN);

    logic [1:0]        state_prev_q, state_prev_d;
    logic [FILT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [1:0]        cmd_active_q, cmd_active_d;
    logic [PIV_W-1:0]  pivot_cnt_q, pivot_cnt_d;
    logic              pivot_q, pivot_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;

    logic              ramp_tick;
    logic              turning;
    logic              dir_keep;
    logic [1:0]        l_dir_tgt, r_dir_tgt;
    logic [CNT_W-1:0]  l_duty_tgt, r_duty_tgt;

    // Debounce: count consecutive identical samples, accept once held long enough
    always_comb begin
        state_prev_d = state;
        if (state != state_prev_q) begin
            stable_cnt_d = FILT_W'(1);
        end else if (stable_cnt_q < FILT_W'(FILTER_CYCLES)) begin
            stable_cnt_d = stable_cnt_q + FILT_W'(1);
        end else begin
            stable_cnt_d = stable_cnt_q;
        end
        cmd_active_d = cmd_active_q;
        if ((stable_cnt_q >= FILT_W'(FILTER_CYCLES)) && (state_prev_q != cmd_active_q)) begin
            cmd_active_d = state_prev_q;
        end
    end

    // Pivot timer: runs during an accepted turn, saturates, clears on any change
    always_comb begin
        turning = (cmd_active_q == CMD_LEFT) || (cmd_active_q == CMD_RIGHT);
        if (cmd_active_d != cmd_active_q) begin
            pivot_cnt_d = '0;
        end else if (!turning) begin
            pivot_cnt_d = '0;
        end else if (pivot_cnt_q != PIV_W'(PIVOT_CYCLES)) begin
            pivot_cnt_d = pivot_cnt_q + PIV_W'(1);
        end else begin
            pivot_cnt_d = pivot_cnt_q;
        end
        pivot_d = (pivot_cnt_d == PIV_W'(PIVOT_CYCLES));
    end

    // Free-running ramp divider and shared PWM counter
    always_comb begin
        ramp_tick = (div_cnt_q == DIV_W'(RAMP_DIV - 1));
        div_cnt_d = ramp_tick ? '0 : (div_cnt_q + DIV_W'(1));
        if (pwm_cnt_q == CNT_W'(PWM_PERIOD - 1)) begin
            pwm_cnt_d = '0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
        end
    end

    // Map the accepted command (and pivot) to per-wheel direction and duty
    always_comb begin
        l_dir_tgt  = DIR_FWD;
        r_dir_tgt  = DIR_FWD;
        l_duty_tgt = '0;
        r_duty_tgt = '0;
        dir_keep   = 1'b0;
        unique case (cmd_active_q)
            CMD_STOP: begin
                dir_keep = 1'b1;
            end
            CMD_FWD: begin
                l_duty_tgt = FULL;
                r_duty_tgt = FULL;
            end
            CMD_LEFT: begin
                l_dir_tgt  = pivot_q ? DIR_REV : DIR_FWD;
                l_duty_tgt = TURN;
                r_duty_tgt = FULL;
            end
            CMD_RIGHT: begin
                r_dir_tgt  = pivot_q ? DIR_REV : DIR_FWD;
                r_duty_tgt = TURN;
                l_duty_tgt = FULL;
            end
            default: begin
                dir_keep = 1'b1;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_prev_q <= CMD_STOP;
            stable_cnt_q <= '0;
            cmd_active_q <= CMD_STOP;
            pivot_cnt_q  <= '0;
            pivot_q      <= 1'b0;
            div_cnt_q    <= '0;
            pwm_cnt_q    <= '0;
        end else begin
            state_prev_q <= state_prev_d;
            stable_cnt_q <= stable_cnt_d;
            cmd_active_q <= cmd_active_d;
            pivot_cnt_q  <= pivot_cnt_d;
            pivot_q      <= pivot_d;
            div_cnt_q    <= div_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
        end
    end

    wheel_channel #(
        .CNT_W       (CNT_W),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_left (
        .clk       (clk),
        .rst_n     (reset),
        .dir_tgt   (l_dir_tgt),
        .dir_keep  (dir_keep),
        .duty_tgt  (l_duty_tgt),
        .ramp_tick (ramp_tick),
        .pwm_cnt   (pwm_cnt_q),
        .pwm       (left_pwm),
        .dir       (left_dir)
    );

    wheel_channel #(
        .CNT_W       (CNT_W),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_right (
        .clk       (clk),
        .rst_n     (reset),
        .dir_tgt   (r_dir_tgt),
        .dir_keep  (dir_keep),
        .duty_tgt  (r_duty_tgt),
        .ramp_tick (ramp_tick),
        .pwm_cnt   (pwm_cnt_q),
        .pwm       (right_pwm),
        .dir       (right_dir)
    );

    assign cmd_active = cmd_active_q;
    assign pivot      = pivot_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_driver
// Description : Self-checking bench for motor_driver using scaled-down
//               parameters: steady-state command table plus hand-written
//               sequences for debounce, ramping, pivot reversal, aborted
//               reversal and reset during the coast interval.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_driver;

    localparam int CNT_W = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state;
    logic       left_pwm, right_pwm;
    logic [1:0] left_dir, right_dir, cmd_active;
    logic       pivot;

    always #5 clk = ~clk;

    motor_driver #(
        .CNT_W(CNT_W), .PWM_PERIOD(10), .DUTY_FULL(8), .DUTY_TURN(4),
        .RAMP_DIV(4), .RAMP_STEP(3), .FILTER_CYCLES(2),
        .PIVOT_CYCLES(40), .DEAD_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .state(state),
        .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_dir(left_dir), .right_dir(right_dir),
        .cmd_active(cmd_active), .pivot(pivot)
    );

    typedef struct {
        logic [1:0] st;
        logic [1:0] cmd;
        logic [1:0] ldir;
        logic [1:0] rdir;
        int         lh;
        int         rh;
        logic       piv;
    } vec_t;

    vec_t tbl [5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count PWM-high cycles over one full PWM period
    task automatic pwm_window(output int lh, output int rh);
        lh = 0;
        rh = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            lh += int'(left_pwm);
            rh += int'(right_pwm);
        end
    endtask

    // Record successive distinct values of the left wheel duty
    task automatic collect_left(input int n, input int bound, output int v [4]);
        int prev;
        int got;
        int k;
        for (int i = 0; i < 4; i++) v[i] = -1;
        prev = int'(dut.u_left.duty_q);
        got  = 0;
        k    = 0;
        while (got < n && k < bound) begin
            step(1);
            k++;
            if (int'(dut.u_left.duty_q) != prev) begin
                prev   = int'(dut.u_left.duty_q);
                v[got] = prev;
                got++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v [4];
        int lh, rh, k, bad, zc, prev, got;

        tbl[0] = '{2'b11, 2'b11, 2'b10, 2'b10, 8, 8, 1'b0};
        tbl[1] = '{2'b01, 2'b01, 2'b10, 2'b10, 4, 8, 1'b0};
        tbl[2] = '{2'b10, 2'b10, 2'b10, 2'b10, 8, 4, 1'b0};
        tbl[3] = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0};
        tbl[4] = '{2'b11, 2'b11, 2'b10, 2'b10, 8, 8, 1'b0};

        // Reset state
        reset = 1'b0;
        state = 2'b00;
        #23;
        check("rst_left_pwm", left_pwm, 0);
        check("rst_right_pwm", right_pwm, 0);
        check("rst_left_dir", left_dir, 0);
        check("rst_right_dir", right_dir, 0);
        check("rst_cmd", cmd_active, 0);
        check("rst_pivot", pivot, 0);
        reset = 1'b1;
        step(3);
        check("idle_cmd", cmd_active, 0);
        check("idle_left_dir", left_dir, 0);

        // Debounce latency and ramp from zero
        state = 2'b11;
        step(2);
        check("filter_not_yet", cmd_active, 0);
        step(1);
        check("filter_accept", cmd_active, 3);
        collect_left(3, 40, v);
        check("ramp_up_0", v[0], 3);
        check("ramp_up_1", v[1], 6);
        check("ramp_up_2", v[2], 8);
        step(2);
        check("fwd_left_dir", left_dir, 2);
        check("fwd_right_dir", right_dir, 2);
        pwm_window(lh, rh);
        check("fwd_left_high", lh, 8);
        check("fwd_right_high", rh, 8);

        // Single-cycle glitch must be ignored
        state = 2'b00;
        step(1);
        state = 2'b11;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cmd_active !== 2'b11 || left_dir !== 2'b10 || right_dir !== 2'b10) bad++;
        end
        check("glitch_hold", bad, 0);
        pwm_window(lh, rh);
        check("glitch_left_high", lh, 8);
        check("glitch_right_high", rh, 8);

        // Steady-state command table
        for (int r = 0; r < 5; r++) begin
            state = tbl[r].st;
            step(18);
            check($sformatf("row%0d_cmd", r), cmd_active, tbl[r].cmd);
            check($sformatf("row%0d_ldir", r), left_dir, tbl[r].ldir);
            check($sformatf("row%0d_rdir", r), right_dir, tbl[r].rdir);
            check($sformatf("row%0d_pivot", r), pivot, tbl[r].piv);
            pwm_window(lh, rh);
            check($sformatf("row%0d_lhigh", r), lh, tbl[r].lh);
            check($sformatf("row%0d_rhigh", r), rh, tbl[r].rh);
        end

        // Left turn escalating to pivot with dead-time reversal
        state = 2'b01;
        k = 0;
        while (cmd_active !== 2'b01 && k < 10) begin step(1); k++; end
        check("left_accept", cmd_active, 1);
        for (int i = 0; i < 4; i++) v[i] = -1;
        prev = int'(dut.u_left.duty_q);
        got = 0;
        for (int i = 0; i < 39; i++) begin
            step(1);
            if (int'(dut.u_left.duty_q) != prev) begin
                prev = int'(dut.u_left.duty_q);
                if (got < 4) v[got] = prev;
                got++;
            end
        end
        check("turn_down_0", v[0], 5);
        check("turn_down_1", v[1], 4);
        check("pivot_early", pivot, 0);
        step(1);
        check("pivot_rise", pivot, 1);
        for (int i = 0; i < 4; i++) v[i] = -1;
        prev = int'(dut.u_left.duty_q);
        got = 0;
        zc = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (left_dir === 2'b00) zc++;
            if (int'(dut.u_left.duty_q) != prev) begin
                prev = int'(dut.u_left.duty_q);
                if (got < 4) v[got] = prev;
                got++;
            end
        end
        check("drain_0", v[0], 1);
        check("drain_1", v[1], 0);
        check("rev_ramp_0", v[2], 3);
        check("rev_ramp_1", v[3], 4);
        check("dead_len", zc, 3);
        check("rev_left_dir", left_dir, 1);
        check("rev_right_dir", right_dir, 2);

        // Return to forward before the aborted-reversal case
        state = 2'b11;
        step(40);
        check("restore_fwd", left_dir, 2);

        // Reversal withdrawn during drain: back to RUN with no coast
        state = 2'b01;
        k = 0;
        while (cmd_active !== 2'b01 && k < 10) begin step(1); k++; end
        k = 0;
        while (pivot !== 1'b1 && k < 60) begin step(1); k++; end
        check("pivot2_rise", pivot, 1);
        state = 2'b11;
        step(1);
        check("abort_in_drain", dut.u_left.state_q, 1);
        zc = (left_dir === 2'b00) ? 1 : 0;
        step(3);
        check("abort_back_run", dut.u_left.state_q, 0);
        check("abort_pivot_clr", pivot, 0);
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (left_dir === 2'b00) zc++;
        end
        check("abort_no_coast", zc, 0);
        check("abort_cmd", cmd_active, 3);
        check("abort_left_dir", left_dir, 2);
        check("abort_left_duty", dut.u_left.duty_q, 8);

        // Reset asserted while the left wheel is coasting
        state = 2'b01;
        k = 0;
        while (left_dir !== 2'b00 && k < 100) begin step(1); k++; end
        check("reach_dead", dut.u_left.state_q, 2);
        #2;
        reset = 1'b0;
        #1;
        check("dead_rst_left_pwm", left_pwm, 0);
        check("dead_rst_right_pwm", right_pwm, 0);
        check("dead_rst_left_dir", left_dir, 0);
        check("dead_rst_right_dir", right_dir, 0);
        check("dead_rst_cmd", cmd_active, 0);
        check("dead_rst_pivot", pivot, 0);
        state = 2'b11;
        #3;
        reset = 1'b1;
        collect_left(3, 40, v);
        check("rst_ramp_0", v[0], 3);
        check("rst_ramp_1", v[1], 6);
        check("rst_ramp_2", v[2], 8);
        step(2);
        check("rst_fwd_left_dir", left_dir, 2);
        check("rst_fwd_right_dir", right_dir, 2);
        check("rst_fwd_cmd", cmd_active, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
